// File: rtl/fb_stream_pkg.sv
// rtl/fb_stream_pkg.sv - shared constants for the framebuffer streamer
package fb_stream_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [2:0] CFG_X_START = 3'd0;
  localparam logic [2:0] CFG_X_END   = 3'd1;
  localparam logic [2:0] CFG_Y_START = 3'd2;
  localparam logic [2:0] CFG_Y_END   = 3'd3;
  localparam logic [2:0] CFG_CTRL    = 3'd4;

  localparam int CTRL_CONT  = 0;
  localparam int CTRL_START = 1;

  function automatic logic [7:0] clamp_coord(input logic [7:0] d, input logic [7:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/fb_stream_if.sv
// rtl/fb_stream_if.sv - valid/ready pixel stream towards the panel block
interface fb_stream_if #(parameter int PIX_W = 16);
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_first;
  logic             pix_last;

  modport master (output pix_data, pix_valid, pix_first, pix_last, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_first, pix_last, output pix_ready);
endinterface

// File: rtl/fb_stream_ram.sv
// rtl/fb_stream_ram.sv - simple dual-port framebuffer, registered read
module fb_stream_ram #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // rdata holds its value until the next read, acting as a one-entry skid stage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fb_stream_controller.sv
// rtl/fb_stream_controller.sv - framebuffer with windowed raster streaming
module fb_stream_controller
  import fb_stream_pkg::*;
#(
  parameter int H_RES   = 128,
  parameter int V_RES   = 128,
  parameter int PIX_W   = 16,
  parameter int COORD_W = 7
) (
  input  logic               clk_main,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               cfg_wr_en,
  input  logic [2:0]         cfg_addr,
  input  logic [7:0]         cfg_data,
  fb_stream_if.master        pix,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy,
  output logic [COORD_W-1:0] win_x0,
  output logic [COORD_W-1:0] win_x1,
  output logic [COORD_W-1:0] win_y0,
  output logic [COORD_W-1:0] win_y1
);
  localparam int AW = $clog2(H_RES * V_RES);
  localparam logic [7:0] X_MAX = 8'(H_RES - 1);
  localparam logic [7:0] Y_MAX = 8'(V_RES - 1);

  logic [2:0]         state;
  logic [COORD_W-1:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  logic               cfg_cont, cfg_start;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               rd_vld, rd_first, rd_last;
  logic               rd_issue, out_load, pix_accept, at_x_end, at_last, wr_ok;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic [PIX_W-1:0]   rd_data;

  assign wr_ok   = wr_en && (8'(wr_x) <= X_MAX) && (8'(wr_y) <= Y_MAX);
  assign wr_addr = AW'(wr_y) * AW'(H_RES) + AW'(wr_x);
  assign rd_addr = AW'(cur_y) * AW'(H_RES) + AW'(cur_x);

  assign cfg_start  = cfg_wr_en && (cfg_addr == CFG_CTRL) && cfg_data[CTRL_START];
  assign at_x_end   = (cur_x == win_x1);
  assign at_last    = at_x_end && (cur_y == win_y1);
  assign pix_accept = pix.pix_valid && pix.pix_ready;
  assign out_load   = rd_vld && (!pix.pix_valid || pix.pix_ready);
  // a new read may replace the RAM output only once its previous data moves on
  assign rd_issue   = (state == ST_STREAM) && enable && !wr_en && (!rd_vld || out_load);

  assign busy        = (state != ST_IDLE);
  assign frame_start = (state == ST_LATCH);
  assign frame_done  = (state == ST_DONE);

  fb_stream_ram #(.DEPTH(H_RES * V_RES), .AW(AW), .DW(PIX_W)) u_ram (
    .clk   (clk_main),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      cfg_x0   <= '0;
      cfg_x1   <= COORD_W'(X_MAX);
      cfg_y0   <= '0;
      cfg_y1   <= COORD_W'(Y_MAX);
      cfg_cont <= 1'b0;
    end else if (cfg_wr_en) begin
      case (cfg_addr)
        CFG_X_START: cfg_x0   <= COORD_W'(clamp_coord(cfg_data, X_MAX));
        CFG_X_END:   cfg_x1   <= COORD_W'(clamp_coord(cfg_data, X_MAX));
        CFG_Y_START: cfg_y0   <= COORD_W'(clamp_coord(cfg_data, Y_MAX));
        CFG_Y_END:   cfg_y1   <= COORD_W'(clamp_coord(cfg_data, Y_MAX));
        CFG_CTRL:    cfg_cont <= cfg_data[CTRL_CONT];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      win_x0 <= '0;
      win_x1 <= COORD_W'(X_MAX);
      win_y0 <= '0;
      win_y1 <= COORD_W'(Y_MAX);
    end else begin
      case (state)
        ST_IDLE: if (cfg_start) state <= ST_LATCH;
        ST_LATCH: begin
          // an inverted axis collapses to a single line at its start
          win_x0 <= cfg_x0;
          win_x1 <= (cfg_x0 > cfg_x1) ? cfg_x0 : cfg_x1;
          win_y0 <= cfg_y0;
          win_y1 <= (cfg_y0 > cfg_y1) ? cfg_y0 : cfg_y1;
          cur_x  <= cfg_x0;
          cur_y  <= cfg_y0;
          state  <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_issue) begin
            if (at_last) begin
              state <= ST_DRAIN;
            end else if (at_x_end) begin
              cur_x <= win_x0;
              cur_y <= cur_y + COORD_W'(1);
            end else begin
              cur_x <= cur_x + COORD_W'(1);
            end
          end
        end
        ST_DRAIN: if (!rd_vld && pix_accept && pix.pix_last) state <= ST_DONE;
        ST_DONE:  state <= cfg_cont ? ST_LATCH : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld        <= 1'b0;
      rd_first      <= 1'b0;
      rd_last       <= 1'b0;
      pix.pix_valid <= 1'b0;
      pix.pix_data  <= '0;
      pix.pix_first <= 1'b0;
      pix.pix_last  <= 1'b0;
    end else begin
      rd_vld <= rd_issue || (rd_vld && !out_load);
      if (rd_issue) begin
        rd_first <= (cur_x == win_x0) && (cur_y == win_y0);
        rd_last  <= at_last;
      end
      if (out_load) begin
        pix.pix_valid <= 1'b1;
        pix.pix_data  <= rd_data;
        pix.pix_first <= rd_first;
        pix.pix_last  <= rd_last;
      end else if (pix_accept) begin
        pix.pix_valid <= 1'b0;
      end
    end
  end
endmodule
